// File: rtl/av_out_pkg.sv
// Shared types and constants for the TinyTapeout A/V output stage.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package av_out_pkg;

    // Audio fade controller states.
    typedef enum logic [1:0] {
        PLAY     = 2'd0,
        FADE_OUT = 2'd1,
        MUTED    = 2'd2,
        FADE_IN  = 2'd3
    } fade_state_t;

    // 2x2 Bayer matrix {{0,2},{3,1}} packed as 2-bit entries indexed by {y,x}.
    localparam logic [7:0] BAYER2 = {2'd1, 2'd3, 2'd2, 2'd0};

    // TinyVGA PMOD pin positions on uo_out.
    localparam int PIN_R1 = 0;
    localparam int PIN_G1 = 1;
    localparam int PIN_B1 = 2;
    localparam int PIN_VS = 3;
    localparam int PIN_R0 = 4;
    localparam int PIN_G0 = 5;
    localparam int PIN_B0 = 6;
    localparam int PIN_HS = 7;

    // Only uio[7] (audio) is ever driven.
    localparam logic [7:0] UIO_OE_AUDIO = 8'h80;

    // Raw dither threshold B[y][x].
    function automatic logic [1:0] bayer2_at(input logic y, input logic x);
        return BAYER2[{y, x, 1'b0} +: 2];
    endfunction

endpackage

// File: rtl/av_out_sdm.sv
// First-order sigma-delta DAC: 1-bit pulse stream whose density is level/2**AUDIO_BITS.
// Latency: 1 clk from level to pulse decision.
// Backpressure: none; clear_i holds the accumulator and output at zero.
module av_out_sdm #(
    parameter int AUDIO_BITS = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  clear_i,
    input  logic [AUDIO_BITS-1:0] level_i,
    output logic                  pdm_o
);

    // Only the low AUDIO_BITS of the accumulator persist; the carry of each
    // new sum is the output pulse and is dropped from the stored value.
    logic [AUDIO_BITS-1:0] acc_q;
    logic [AUDIO_BITS:0]   sum_d;
    logic                  pdm_q;

    assign sum_d = {1'b0, acc_q} + {1'b0, level_i};
    assign pdm_o = pdm_q;

    // Accumulate and emit the carry; clear forces silence.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_q <= '0;
            pdm_q <= 1'b0;
        end else if (clear_i) begin
            acc_q <= '0;
            pdm_q <= 1'b0;
        end else begin
            acc_q <= sum_d[AUDIO_BITS-1:0];
            pdm_q <= sum_d[AUDIO_BITS];
        end
    end

endmodule

// File: rtl/tt_av_out.sv
// A/V pin stage: sync delay, 2x2 ordered dither to rgb222 (macro TT_AV_OUT_DITHER_EN), sigma-delta audio with fade mute.
// Latency: video 1 enable cycle (syncs +SYNC_DELAY enable cycles); audio 1 clk.
// Backpressure: none; enable low freezes the video path, audio always runs.
module tt_av_out
    import av_out_pkg::*;
#(
    parameter int COLOR_BITS = 4,
    parameter int AUDIO_BITS = 8,
    parameter int SYNC_DELAY = 0,
    parameter int GAIN_BITS  = 4,
    parameter int FADE_DIV   = 256
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  enable,
    input  logic [COLOR_BITS-1:0] r,
    input  logic [COLOR_BITS-1:0] g,
    input  logic [COLOR_BITS-1:0] b,
    input  logic                  hsync,
    input  logic                  vsync,
    input  logic                  sync_invert,
    input  logic [AUDIO_BITS-1:0] audio_sample,
    input  logic                  pause,
    output logic [7:0]            uo_out,
    output logic [7:0]            uio_out,
    output logic [7:0]            uio_oe
);

    localparam int GW    = GAIN_BITS + 1;
    localparam int PRE_W = (FADE_DIV > 1) ? $clog2(FADE_DIV) : 1;
    localparam int T_SHL = (COLOR_BITS >= 4) ? COLOR_BITS - 4 : 0;
    localparam logic [GW-1:0] GAIN_MAX = GW'(2 ** GAIN_BITS);

    // Bring the 2-bit Bayer threshold to the input colour scale.
    function automatic logic [COLOR_BITS-1:0] scale_t(input logic [1:0] t);
        logic [COLOR_BITS+1:0] w;
        w = {{COLOR_BITS{1'b0}}, t};
        if (COLOR_BITS >= 4)      w = w << T_SHL;
        else if (COLOR_BITS == 3) w = w >> 1;
        else                      w = '0;
        return w[COLOR_BITS-1:0];
    endfunction

    // Add threshold one bit wider than the channel, then keep the top two bits, clamped.
    function automatic logic [1:0] quant(input logic [COLOR_BITS-1:0] c,
                                         input logic [COLOR_BITS-1:0] t);
        logic [COLOR_BITS:0] sum;
        logic [COLOR_BITS:0] q;
        sum = {1'b0, c} + {1'b0, t};
        q   = sum >> (COLOR_BITS - 2);
        return (q > (COLOR_BITS + 1)'(3)) ? 2'd3 : q[1:0];
    endfunction

    // ---------------- video ----------------
    logic hs_dly, vs_dly;

    generate
        if (SYNC_DELAY == 0) begin : g_nodly
            assign hs_dly = hsync;
            assign vs_dly = vsync;
        end else begin : g_dly
            logic [SYNC_DELAY-1:0] hs_dly_q, vs_dly_q;
            // Shift raw syncs through SYNC_DELAY enable-strobed stages.
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    hs_dly_q <= '0;
                    vs_dly_q <= '0;
                end else if (enable) begin
                    hs_dly_q <= (hs_dly_q << 1) | SYNC_DELAY'(hsync);
                    vs_dly_q <= (vs_dly_q << 1) | SYNC_DELAY'(vsync);
                end
            end
            assign hs_dly = hs_dly_q[SYNC_DELAY-1];
            assign vs_dly = vs_dly_q[SYNC_DELAY-1];
        end
    endgenerate

    logic [1:0] t_raw;

`ifdef TT_AV_OUT_DITHER_EN
    logic x_par_q, y_par_q, hs_prev_q;
    // Pixel/line parities: x restarts in hsync, y flips on hsync rise and restarts in vsync.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            x_par_q   <= 1'b0;
            y_par_q   <= 1'b0;
            hs_prev_q <= 1'b0;
        end else if (enable) begin
            x_par_q   <= hsync ? 1'b0 : ~x_par_q;
            if (vsync)                  y_par_q <= 1'b0;
            else if (hsync && !hs_prev_q) y_par_q <= ~y_par_q;
            hs_prev_q <= hsync;
        end
    end
    assign t_raw = bayer2_at(y_par_q, x_par_q);
`else
    assign t_raw = 2'd0;
`endif

    logic [COLOR_BITS-1:0] t_s;
    logic [1:0]            q_r, q_g, q_b;
    logic [7:0]            uo_d, uo_q;

    assign t_s = scale_t(t_raw);
    assign q_r = quant(r, t_s);
    assign q_g = quant(g, t_s);
    assign q_b = quant(b, t_s);

    // Arrange quantised colour and polarity-adjusted syncs in TinyVGA pin order.
    always_comb begin
        uo_d         = '0;
        uo_d[PIN_HS] = hs_dly ^ sync_invert;
        uo_d[PIN_VS] = vs_dly ^ sync_invert;
        uo_d[PIN_R1] = q_r[1];
        uo_d[PIN_R0] = q_r[0];
        uo_d[PIN_G1] = q_g[1];
        uo_d[PIN_G0] = q_g[0];
        uo_d[PIN_B1] = q_b[1];
        uo_d[PIN_B0] = q_b[0];
    end

    // Pin register, advances only on pixel strobes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)      uo_q <= '0;
        else if (enable) uo_q <= uo_d;
    end

    assign uo_out = uo_q;

    // ---------------- audio ----------------
    fade_state_t       state_q, state_d;
    logic [GW-1:0]     gain_q, gain_d;
    logic [PRE_W-1:0]  pre_q, pre_d;
    logic              step;

    assign step = (pre_q == PRE_W'(FADE_DIV - 1));

    // Fade controller: one gain step per FADE_DIV clocks; reversals keep the current gain.
    always_comb begin
        state_d = state_q;
        gain_d  = gain_q;
        pre_d   = step ? '0 : pre_q + 1'b1;
        case (state_q)
            PLAY: begin
                gain_d = GAIN_MAX;
                if (pause) state_d = FADE_OUT;
            end
            FADE_OUT: begin
                if (!pause)              state_d = FADE_IN;
                else if (gain_q == '0)   state_d = MUTED;
                else if (step) begin
                    gain_d = gain_q - 1'b1;
                    if (gain_q == GW'(1)) state_d = MUTED;
                end
            end
            MUTED: begin
                gain_d = '0;
                if (!pause) state_d = FADE_IN;
            end
            FADE_IN: begin
                if (pause)                    state_d = FADE_OUT;
                else if (gain_q == GAIN_MAX)  state_d = PLAY;
                else if (step) begin
                    gain_d = gain_q + 1'b1;
                    if (gain_q == GAIN_MAX - 1'b1) state_d = PLAY;
                end
            end
            default: begin
                state_d = FADE_IN;
                gain_d  = '0;
            end
        endcase
        if (state_d != state_q) pre_d = '0;
    end

    // Fade state, gain and prescaler registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FADE_IN;
            gain_q  <= '0;
            pre_q   <= '0;
        end else begin
            state_q <= state_d;
            gain_q  <= gain_d;
            pre_q   <= pre_d;
        end
    end

    logic [AUDIO_BITS+GW-1:0] prod;
    logic [AUDIO_BITS-1:0]    scaled;
    logic                     pdm;

    // gain never exceeds unity, so the shifted product always fits AUDIO_BITS.
    assign prod   = {{GW{1'b0}}, audio_sample} * {{AUDIO_BITS{1'b0}}, gain_q};
    assign scaled = AUDIO_BITS'(prod >> GAIN_BITS);

    av_out_sdm #(
        .AUDIO_BITS (AUDIO_BITS)
    ) u_sdm (
        .clk     (clk),
        .rst_n   (rst_n),
        .clear_i (state_q == MUTED),
        .level_i (scaled),
        .pdm_o   (pdm)
    );

    assign uio_out = {pdm, 7'b0};
    assign uio_oe  = UIO_OE_AUDIO;

endmodule

// File: tb/tb_tt_av_out.sv
// Directed bench for tt_av_out: pin order, dither, sync delay, audio density, fade, async reset.
// u_a: COLOR_BITS=2, no sync delay. u_b: COLOR_BITS=4, SYNC_DELAY=2, FADE_DIV=4.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
module tb_tt_av_out;
    import av_out_pkg::*;

    logic       clk = 1'b0;
    logic       rst_n, enable, hsync, vsync, sync_invert, pause;
    logic [1:0] ra, ga, ba;
    logic [3:0] rb, gb, bb;
    logic [7:0] sample;
    logic [7:0] uo_a, uio_a, oe_a, uo_b, uio_b, oe_b;
    int         n_chk = 0;
    int         n_bad = 0;

    always #5 clk = ~clk;

    tt_av_out #(.COLOR_BITS(2), .AUDIO_BITS(8), .SYNC_DELAY(0), .GAIN_BITS(4), .FADE_DIV(256)) u_a (
        .clk(clk), .rst_n(rst_n), .enable(enable), .r(ra), .g(ga), .b(ba),
        .hsync(hsync), .vsync(vsync), .sync_invert(sync_invert),
        .audio_sample(sample), .pause(pause),
        .uo_out(uo_a), .uio_out(uio_a), .uio_oe(oe_a));

    tt_av_out #(.COLOR_BITS(4), .AUDIO_BITS(8), .SYNC_DELAY(2), .GAIN_BITS(4), .FADE_DIV(4)) u_b (
        .clk(clk), .rst_n(rst_n), .enable(enable), .r(rb), .g(gb), .b(bb),
        .hsync(hsync), .vsync(vsync), .sync_invert(sync_invert),
        .audio_sample(sample), .pause(pause),
        .uo_out(uo_b), .uio_out(uio_b), .uio_oe(oe_b));

`ifdef TT_AV_OUT_DITHER_EN
    localparam logic [5:0] D_Y1X0 = 6'b101010;
`else
    localparam logic [5:0] D_Y1X0 = 6'b010101;
`endif
    localparam logic [5:0] RGB_1 = 6'b010101;
    localparam logic [5:0] RGB_3 = 6'b111111;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // {r1,r0,g1,g0,b1,b0} picked from the TinyVGA pin positions.
    function automatic logic [5:0] rgb(input logic [7:0] u);
        return {u[0], u[4], u[1], u[5], u[2], u[6]};
    endfunction

    task automatic count_ones(input int n, output int ones);
        ones = 0;
        repeat (n) begin
            tick();
            if (uio_b[7]) ones++;
        end
    endtask

    task automatic set_cb(input logic [3:0] c);
        rb = c; gb = c; bb = c;
    endtask

    int ones;
    logic found;

    initial begin
        rst_n = 1'b0; enable = 1'b0; hsync = 1'b0; vsync = 1'b0; sync_invert = 1'b0;
        pause = 1'b0; ra = '0; ga = '0; ba = '0; rb = '0; gb = '0; bb = '0; sample = '0;
        #23;
        chk("rst_uo_a", uo_a, 8'h00);
        chk("rst_uo_b", uo_b, 8'h00);
        chk("rst_uio_b", uio_b, 8'h00);
        chk("rst_oe", oe_b, 8'h80);
        chk("rst_gain", u_b.gain_q, 0);
        chk("rst_state", 32'(u_b.state_q), 32'(FADE_IN));
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // Pin order and sync polarity.
        ra = 2'd3; ga = 2'd0; ba = 2'd2; hsync = 1'b1; vsync = 1'b0; enable = 1'b1;
        tick();
        chk("pin_order", uo_a, 8'h95);
        sync_invert = 1'b1;
        tick();
        chk("pin_invert", uo_a, 8'h1D);
        enable = 1'b0; ra = 2'd0; ga = 2'd3; ba = 2'd1; hsync = 1'b0; vsync = 1'b1; sync_invert = 1'b0;
        tick(5);
        chk("freeze_uo", uo_a, 8'h1D);

        // Dither 2x2 over two lines, c=5.
        set_cb(4'd5); enable = 1'b1;
        vsync = 1'b1; hsync = 1'b1; tick();
        vsync = 1'b0; hsync = 1'b0; tick();
        chk("dith_y0x0", rgb(uo_b), RGB_1);
        tick();
        chk("dith_y0x1", rgb(uo_b), RGB_1);
        hsync = 1'b1; tick();
        hsync = 1'b0; tick();
        chk("dith_y1x0", rgb(uo_b), D_Y1X0);
        enable = 1'b0; hsync = 1'b1; tick(4);
        hsync = 1'b0; enable = 1'b1; tick();
        chk("dith_y1x1_after_gap", rgb(uo_b), RGB_1);
        set_cb(4'd15);
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("dith_sat", rgb(uo_b), RGB_3);
        end

        // Sync delay of 2 enable cycles; colour keeps 1-cycle latency.
        set_cb(4'd0); hsync = 1'b0; vsync = 1'b0;
        tick(3);
        hsync = 1'b1; set_cb(4'd12); tick();
        chk("sd_n_hs", uo_b[7], 1'b0);
        chk("sd_n_col", rgb(uo_b), RGB_3);
        hsync = 1'b0; set_cb(4'd0); tick();
        chk("sd_n1_hs", uo_b[7], 1'b0);
        chk("sd_n1_col", rgb(uo_b), 6'b000000);
        tick();
        chk("sd_n2_hs", uo_b[7], 1'b1);
        tick();
        chk("sd_n3_hs", uo_b[7], 1'b0);
        hsync = 1'b1; tick();
        hsync = 1'b0; enable = 1'b0; tick(3);
        chk("sd_gap_hs", uo_b[7], 1'b0);
        enable = 1'b1; tick();
        chk("sd_gap_n1_hs", uo_b[7], 1'b0);
        tick();
        chk("sd_gap_n2_hs", uo_b[7], 1'b1);

        // Audio density at unity gain.
        tick(80);
        chk("play_state", 32'(u_b.state_q), 32'(PLAY));
        chk("play_gain", u_b.gain_q, 16);
        sample = 8'd64; tick(8);
        count_ones(256, ones);
        chk("dens_64", ones, 64);
        chk("uio_low_zero", uio_b[6:0], 7'd0);
        sample = 8'd0; tick(8);
        count_ones(256, ones);
        chk("dens_0", ones, 0);
        sample = 8'd255; tick(8);
        count_ones(256, ones);
        chk("dens_255", ones, 255);

        // Full fade out to mute.
        pause = 1'b1; tick();
        chk("fo_state", 32'(u_b.state_q), 32'(FADE_OUT));
        tick(63);
        chk("fo_gain63", u_b.gain_q, 1);
        chk("fo_state63", 32'(u_b.state_q), 32'(FADE_OUT));
        tick();
        chk("muted_state", 32'(u_b.state_q), 32'(MUTED));
        chk("muted_gain", u_b.gain_q, 0);
        tick(2);
        count_ones(50, ones);
        chk("muted_silent", ones, 0);

        // Fade in from mute.
        pause = 1'b0; tick();
        chk("fi_state", 32'(u_b.state_q), 32'(FADE_IN));
        tick(63);
        chk("fi_gain63", u_b.gain_q, 15);
        tick();
        chk("fi_play", 32'(u_b.state_q), 32'(PLAY));

        // Reverse mid-fade at gain 8.
        pause = 1'b1; tick(33);
        chk("mid_gain8", u_b.gain_q, 8);
        pause = 1'b0; tick();
        chk("mid_fi_state", 32'(u_b.state_q), 32'(FADE_IN));
        chk("mid_fi_gain", u_b.gain_q, 8);
        tick(31);
        chk("mid_gain15", u_b.gain_q, 15);
        tick();
        chk("mid_play", 32'(u_b.state_q), 32'(PLAY));

        // pause toggling every cycle never steps the gain.
        for (int i = 0; i < 40; i++) begin
            pause = ~pause;
            tick();
            chk("toggle_gain", u_b.gain_q, 16);
        end
        pause = 1'b0; tick(4);

        // Async reset between edges with video and audio active.
        ra = 2'd3; ga = 2'd0; ba = 2'd2; hsync = 1'b1; vsync = 1'b0; sync_invert = 1'b0;
        enable = 1'b1; sample = 8'd255;
        found = 1'b0;
        for (int i = 0; i < 16 && !found; i++) begin
            tick();
            if (uio_b[7]) found = 1'b1;
        end
        chk("pre_rst_pdm", found, 1'b1);
        chk("pre_rst_uo", uo_a, 8'h95);
        #2 rst_n = 1'b0;
        #1;
        chk("arst_uo_a", uo_a, 8'h00);
        chk("arst_uo_b", uo_b, 8'h00);
        chk("arst_uio_b", uio_b, 8'h00);
        chk("arst_oe", oe_b, 8'h80);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
